// File: rtl/frame_buffer_writer_pkg.sv
// Shared display definitions: default raster geometry, pixel width and the
// state encoding of the frame writer.
package frame_buffer_writer_pkg;

   localparam int DEF_IMG_W  = 320;
   localparam int DEF_IMG_H  = 240;
   localparam int DEF_ADDR_W = 17;
   localparam int PIX_W      = 24;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      WRITE    = 2'd2
   } fbw_state_e;

   // Counter width for a range of v values, never narrower than one bit.
   function automatic int cnt_width(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/frame_buffer_writer_raster_addr_counter.sv
// Raster position tracker: column, row and the running base address of the
// current line. The outputs describe the pixel being offered right now; when
// restart is high that pixel is taken as the first of the frame.
module raster_addr_counter
   import frame_buffer_writer_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              restart,
   input  logic              advance,
   input  logic              next_line,
   output logic [ADDR_W-1:0] addr,
   output logic              last_col,
   output logic              done
);

   localparam int COL_W = cnt_width(IMG_W);
   localparam int ROW_W = cnt_width(IMG_H);

   logic [COL_W-1:0]  col_q, col_d, cur_col;
   logic [ROW_W-1:0]  row_q, row_d, cur_row;
   logic [ADDR_W-1:0] base_q, base_d, cur_base;
   logic              last_row;

   // Position of the pixel on offer: a restarting pixel always sits at 0/0.
   always_comb begin
      cur_col  = col_q;
      cur_row  = row_q;
      cur_base = base_q;
      if (restart) begin
         cur_col  = '0;
         cur_row  = '0;
         cur_base = '0;
      end
   end

   assign addr     = cur_base + ADDR_W'(cur_col);
   assign last_col = (cur_col == COL_W'(IMG_W - 1));
   assign last_row = (cur_row == ROW_W'(IMG_H - 1));
   assign done     = last_col & last_row;

   // Step to the next pixel or the next line; line_base is a running sum so
   // no multiplier is needed. A line break out of the last row (only possible
   // after an early end-of-line) folds back to row 0 to keep addresses in range.
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      base_d = base_q;
      if (clear) begin
         col_d  = '0;
         row_d  = '0;
         base_d = '0;
      end else if (advance) begin
         if (next_line) begin
            col_d = '0;
            if (last_row) begin
               row_d  = '0;
               base_d = '0;
            end else begin
               row_d  = cur_row + ROW_W'(1);
               base_d = cur_base + ADDR_W'(IMG_W);
            end
         end else begin
            col_d  = cur_col + COL_W'(1);
            row_d  = cur_row;
            base_d = cur_base;
         end
      end
   end

   // Position registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         col_q  <= '0;
         row_q  <= '0;
         base_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         base_q <= base_d;
      end
   end

endmodule

// File: rtl/frame_buffer_writer.sv
// Frame writer: takes a raster pixel stream and writes one frame per start
// pulse into a single-port 24-bit RAM, flagging raster-sync errors.
module frame_buffer_writer
   import frame_buffer_writer_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [PIX_W-1:0]  s_data,
   input  logic              s_sof,
   input  logic              s_eol,
   output logic [ADDR_W-1:0] mem_address,
   output logic [PIX_W-1:0]  mem_data,
   output logic              mem_wren,
   output logic              busy,
   output logic              frame_done,
   output logic              err_sync
);

   fbw_state_e        state_q, state_d;
   logic              beat;
   logic              wr_en;
   logic              sync_err;
   logic              cnt_clear;
   logic              cnt_restart;
   logic              next_line;
   logic [ADDR_W-1:0] cnt_addr;
   logic              cnt_last_col;
   logic              cnt_done;

   logic              mem_wren_q, mem_wren_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [PIX_W-1:0]  mem_data_q, mem_data_d;
   logic              frame_done_q, frame_done_d;
   logic              err_sync_q, err_sync_d;

   // Ready and busy are pure decodes of the state register, so there is no
   // combinational path from s_valid back to s_ready.
   assign s_ready = (state_q == WAIT_SOF) || (state_q == WRITE);
   assign busy    = (state_q != IDLE);
   assign beat    = s_valid & s_ready;

   // Classify the current beat: whether it is written and whether it breaks
   // the raster. Beats before the first start-of-frame are dropped silently.
   always_comb begin
      wr_en = 1'b0;
      case (state_q)
         WAIT_SOF: wr_en = beat & s_sof;
         WRITE:    wr_en = beat;
         default:  wr_en = 1'b0;
      endcase
      cnt_clear   = (state_q == IDLE) & start;
      cnt_restart = wr_en & s_sof;
      next_line   = s_eol | cnt_last_col;
      // Early end-of-line, missing end-of-line (except on the final pixel)
      // and a start-of-frame inside a frame are all sync errors.
      sync_err    = wr_en & (((state_q == WRITE) & s_sof)
                             | (s_eol & ~cnt_last_col)
                             | (~s_eol & cnt_last_col & ~cnt_done));
   end

   raster_addr_counter #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_raster_addr_counter (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (cnt_clear),
      .restart   (cnt_restart),
      .advance   (wr_en),
      .next_line (next_line),
      .addr      (cnt_addr),
      .last_col  (cnt_last_col),
      .done      (cnt_done)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start only counts when idle; the final pixel returns
   // to idle whether it was reached from WRITE or (single-pixel frame) WAIT_SOF.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = WAIT_SOF;
         end
         WAIT_SOF: begin
            if (wr_en) state_d = cnt_done ? IDLE : WRITE;
         end
         WRITE: begin
            if (wr_en && cnt_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: one-cycle registered write port, completion pulse and the
   // sticky error, which only an accepted start clears.
   always_comb begin
      mem_wren_d    = wr_en;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      frame_done_d  = wr_en & cnt_done;
      err_sync_d    = err_sync_q | sync_err;
      if (wr_en) begin
         mem_address_d = cnt_addr;
         mem_data_d    = s_data;
      end
      if (cnt_clear) begin
         err_sync_d = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_wren_q    <= 1'b0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         frame_done_q  <= 1'b0;
         err_sync_q    <= 1'b0;
      end else begin
         mem_wren_q    <= mem_wren_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         frame_done_q  <= frame_done_d;
         err_sync_q    <= err_sync_d;
      end
   end

   assign mem_wren    = mem_wren_q;
   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;
   assign frame_done  = frame_done_q;
   assign err_sync    = err_sync_q;

endmodule
